// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - opcodes, ALU function codes and FSM states for the calculator sequencer
package calc_pkg;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_LOAD = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_MUL  = 4'd4;
    localparam logic [3:0] OP_DIV  = 4'd5;
    localparam logic [3:0] OP_CLR  = 4'd6;
    localparam logic [3:0] OP_READ = 4'd7;

    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_SUB = 2'd1;
    localparam logic [1:0] ALU_MUL = 2'd2;
    localparam logic [1:0] ALU_DIV = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    function automatic logic is_alu_op(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL) || (op == OP_DIV);
    endfunction

    function automatic logic [1:0] alu_fn(input logic [3:0] op);
        logic [1:0] fn;
        case (op)
            OP_SUB:  fn = ALU_SUB;
            OP_MUL:  fn = ALU_MUL;
            OP_DIV:  fn = ALU_DIV;
            default: fn = ALU_ADD;
        endcase
        return fn;
    endfunction

endpackage

// File: rtl/calc_timeout_ctr.sv
// rtl/calc_timeout_ctr.sv - clearable cycle counter flagging the last allowed wait cycle
module calc_timeout_ctr #(
    parameter int TW      = 5,
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [TW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + TW'(1);
        end
    end

    // Expired on the TIMEOUT-th enabled cycle after a clear.
    assign expired = (count == TW'(TIMEOUT - 1));

endmodule

// File: rtl/calc_op_sequencer.sv
// rtl/calc_op_sequencer.sv - sequences accumulator updates and the shared multi-cycle ALU per host command
module calc_op_sequencer
    import calc_pkg::*;
#(
    parameter int N       = 8,
    parameter int TIMEOUT = 16,
    parameter int TW      = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [3:0]   cmd_op,
    input  logic [N-1:0] cmd_data,
    input  logic [N-1:0] acc_q,
    output logic [N-1:0] acc_d,
    output logic         alu_start,
    output logic [1:0]   alu_op,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    input  logic         alu_done,
    input  logic [N-1:0] alu_result,
    input  logic         alu_err,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [N-1:0] rsp_data,
    output logic         rsp_err,
    output logic         busy
);

    state_t       state;
    state_t       state_nxt;
    logic [3:0]   op_r;
    logic [N-1:0] data_r;
    logic [N-1:0] rsp_data_r;
    logic         rsp_err_r;
    logic         accept;
    logic         expired;
    logic         rsp_upd;
    logic [N-1:0] rsp_data_nxt;
    logic         rsp_err_nxt;

    assign accept = cmd_valid && cmd_ready;

    calc_timeout_ctr #(
        .TW      (TW),
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clr     (state == S_ISSUE),
        .en      (state == S_WAIT),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = is_alu_op(cmd_op) ? S_ISSUE : S_RESP;
                end
            end
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT: begin
                if (alu_done || expired) begin
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // The accumulator has no enable, so acc_d must recirculate acc_q unless this cycle commits an update.
    always_comb begin
        cmd_ready    = (state == S_IDLE);
        busy         = (state != S_IDLE);
        rsp_valid    = (state == S_RESP);
        alu_start    = (state == S_ISSUE);
        alu_op       = alu_fn(op_r);
        alu_a        = acc_q;
        alu_b        = data_r;
        acc_d        = acc_q;
        rsp_upd      = 1'b0;
        rsp_data_nxt = acc_q;
        rsp_err_nxt  = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept && !is_alu_op(cmd_op)) begin
                    rsp_upd = 1'b1;
                    case (cmd_op)
                        OP_LOAD: acc_d = cmd_data;
                        OP_CLR:  acc_d = '0;
                        OP_NOP, OP_READ: acc_d = acc_q;
                        default: rsp_err_nxt = 1'b1;
                    endcase
                    rsp_data_nxt = acc_d;
                end
            end
            S_WAIT: begin
                if (alu_done) begin
                    rsp_upd = 1'b1;
                    if (alu_err) begin
                        rsp_err_nxt = 1'b1;
                    end else begin
                        acc_d        = alu_result;
                        rsp_data_nxt = alu_result;
                    end
                end else if (expired) begin
                    rsp_upd     = 1'b1;
                    rsp_err_nxt = 1'b1;
                end
            end
            default: ;
        endcase
        if (rst) begin
            acc_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_r       <= OP_NOP;
            data_r     <= '0;
            rsp_data_r <= '0;
            rsp_err_r  <= 1'b0;
        end else begin
            if (accept) begin
                op_r   <= cmd_op;
                data_r <= cmd_data;
            end
            if (rsp_upd) begin
                rsp_data_r <= rsp_data_nxt;
                rsp_err_r  <= rsp_err_nxt;
            end
        end
    end

    assign rsp_data = rsp_data_r;
    assign rsp_err  = rsp_err_r;

endmodule
